memory_wrapped: RTL and testbench
=================================

# memory_wrapped

Dual-port on-chip memory that serves as the boot/program RAM at the 0xF000_0000 region of the SoC. It presents two independent bus-slave ports, one for the core instruction bus and one for the data bus, on top of a single shared word array. The array is loadable from a hex image at simulation start. Address decode and `ss` generation are done by the interconnect in the top level.

## Interface
- `DEPTH`, 1024: memory size in 32-bit words; must be ≥1001 so the boot image range 0..1000 fits.
- `AW`, `$clog2(DEPTH)`: word-index width.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst_n`  input  1  reset; asynchronous, active-low.
- `ibus`, `dbus`: two identical `slave_bus_if` ports. Per port:
- `ss`  input  1  slave select from the interconnect decoder.
- `bstart`  input  1  transaction request; held by the master until `bdone`.
- `ttype`  input  1  0 = read, 1 = write. Tied to 0 when unconnected.
- `addr`  input  32  byte address; only `addr[AW+1:0]` is used, upper bits ignored.
- `tsize`  input  2  access size: 00 = byte, 01 = half, 10 = word; 11 is treated as word.
- `wdata`  input  32  write data, right-aligned (byte in [7:0], half in [15:0]).
- `rdata`  output  32  read data, right-aligned and zero-extended.
- `bdone`  output  1  one-cycle completion strobe.
- `berror`  output  1  one-cycle error strobe: misaligned access.
- Storage is a submodule instance named `wrapped_mem` containing `logic [31:0] mem [0:DEPTH-1]`. The hierarchical path `mem0.wrapped_mem.mem` must remain valid for `$readmemh`.

## Operation
- **Accept condition:** a port accepts a transaction on a rising edge where `ss && bstart && !bdone` holds. The `!bdone` term prevents re-accepting a request the master has not yet dropped.
- **Word index:** `addr[AW+1:2]`. Byte lane is `addr[1:0]`.
- **Alignment:**
  - Half requires `addr[0]==0`.
  - Word requires `addr[1:0]==0`.
  - A misaligned access performs no write, returns `rdata=0`, and pulses `berror` together with `bdone`.
- **Read:** the selected byte or half is shifted to bit 0 and zero-extended; a word is returned as-is. `rdata` is registered and holds its value until the next completed read on that port.
- **Write:** only the addressed lanes are updated, using `wdata[7:0]`, `wdata[15:0]`, or `wdata[31:0]` placed at the lane offset. A write leaves `rdata` unchanged.
- Each port is independent; both ports may be accepted on the same edge.
- **Same-word collision:** a read returns the old contents (read-before-write). On simultaneous writes to the same word, `dbus` wins for overlapping lanes; non-overlapping lanes from both ports are written.
- Memory contents are not cleared by reset. Uninitialised words read as X in simulation.

## Timing
- **Latency:** the access is performed at the accepting edge (T0). `bdone` and `rdata` are registered outputs and are valid from T0 until T0+1.
- `bdone` is high for exactly one cycle per transaction.
- The master must drop or change `bstart` on the edge where it samples `bdone`. If `bstart` is still high in the cycle after `bdone`, that is a new transaction.
- Peak throughput is one transaction per 2 cycles per port.
- **Reset:**
  - While `rst_n==0`: `bdone=0`, `berror=0`, `rdata=0` on both ports, and no transaction is accepted.
  - Asserting reset mid-transaction drops the pending `bdone`.
  - A write committed at an earlier edge stays committed.
- If `ss` is low, `bstart` is ignored and the outputs keep their idle values (`bdone=0`, `berror=0`).

## Test plan
- **Boot image:** preload `mem[0]=0x00000013` and `mem[1]=0xDEADBEEF`. An `ibus` word read at 0xF000_0000 gives `rdata=0x00000013` with `bdone` one cycle after the accepting edge. A read at 0xF000_0004 gives 0xDEADBEEF.
- **Sub-word access:**
  - `dbus` byte write 0xAB to 0xF000_0102, then word read of 0xF000_0100 → bits[23:16]=0xAB, other lanes unchanged.
  - Half read at 0xF000_0102 → 0x0000_00AB if bits[31:24] are 0.
- **Misaligned:** a `dbus` word write to 0xF000_0001 pulses `berror` and `bdone` together, and memory is unchanged.
- **Dual-port collision:** on the same edge, `dbus` writes 0x12345678 to word 8 while `ibus` reads word 8. `ibus` returns the old value; a subsequent read returns 0x12345678.
- **Handshake:**
  - Holding `bstart` high continuously yields `bdone` pulses every 2 cycles.
  - `bstart` high with `ss=0` produces no `bdone`.
- **Reset:** assert `rst_n=0` one cycle after a request is accepted. `bdone`, `berror` and `rdata` go to 0 immediately (asynchronously), and the previously written data persists after reset.

Source files
------------

// File: rtl/memory_wrapped_if.sv
// rtl/memory_wrapped_if.sv - slave bus interface shared by the ibus and dbus ports
//
// Purpose: bundles one bus-slave port of the boot/program RAM.
// Signals:
//   ss      master->slave  slave select from the interconnect decoder
//   bstart  master->slave  transaction request, held until bdone
//   ttype   master->slave  0 = read, 1 = write
//   addr    master->slave  byte address
//   tsize   master->slave  00 byte, 01 half, 10/11 word
//   wdata   master->slave  right-aligned write data
//   rdata   slave->master  right-aligned, zero-extended read data
//   bdone   slave->master  one-cycle completion strobe
//   berror  slave->master  one-cycle misalignment strobe (with bdone)
interface slave_bus_if;
  logic        ss;
  logic        bstart;
  logic        ttype;
  logic [31:0] addr;
  logic [1:0]  tsize;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        bdone;
  logic        berror;

  modport master (
    output ss, bstart, ttype, addr, tsize, wdata,
    input  rdata, bdone, berror
  );

  modport slave (
    input  ss, bstart, ttype, addr, tsize, wdata,
    output rdata, bdone, berror
  );
endinterface

// File: rtl/memory_wrapped.sv
// rtl/memory_wrapped.sv - dual-port boot/program RAM with two bus-slave ports
//
// Purpose: one shared 32-bit word array served by two independent slave
// ports (instruction bus and data bus). Accesses complete at the accepting
// edge; bdone/berror/rdata are registered.
// Ports (memory_wrapped):
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (outputs only; array keeps contents)
//   ibus   slave_bus_if.slave, instruction-bus port
//   dbus   slave_bus_if.slave, data-bus port (wins lane conflicts on writes)

// Word array with two byte-enabled write ports and two asynchronous reads.
// Ports: clk, a_*/b_* index, byte-enable and lane-placed write data,
// a_rword_o/b_rword_o current contents of the indexed words.
module memory_wrapped_mem #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [AW-1:0] a_idx_i,
  input  logic [3:0]    a_be_i,
  input  logic [31:0]   a_wdata_i,
  input  logic [AW-1:0] b_idx_i,
  input  logic [3:0]    b_be_i,
  input  logic [31:0]   b_wdata_i,
  output logic [31:0]   a_rword_o,
  output logic [31:0]   b_rword_o
);
  logic [31:0] mem [0:DEPTH-1];

  // Reads see the pre-edge contents, giving read-before-write on collisions.
  assign a_rword_o = mem[a_idx_i];
  assign b_rword_o = mem[b_idx_i];

  // Port b is written after port a, so on the same word its lanes win.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (a_be_i[i]) mem[a_idx_i][8*i +: 8] <= a_wdata_i[8*i +: 8];
      if (b_be_i[i]) mem[b_idx_i][8*i +: 8] <= b_wdata_i[8*i +: 8];
    end
  end
endmodule

// Per-port control: accept, alignment check, lane steering, output registers.
// Ports: clk, rst_n, bus (slave modport), rword_i word read from the array,
// idx_o word index, be_o gated write byte-enables, wdata_o lane-placed data.
module memory_wrapped_port #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  slave_bus_if.slave    bus,
  input  logic [31:0]   rword_i,
  output logic [AW-1:0] idx_o,
  output logic [3:0]    be_o,
  output logic [31:0]   wdata_o
);
  logic        bdone_q, berror_q;
  logic [31:0] rdata_q;
  logic        accept;
  logic        misaligned;
  logic [1:0]  lane;
  logic [3:0]  be_sel;
  logic [31:0] shifted;
  logic [31:0] rfmt;
  logic        unused_addr;

  assign unused_addr = ^bus.addr[31:AW+2];
  assign lane        = bus.addr[1:0];
  assign idx_o       = bus.addr[AW+1:2];

  // !bdone_q stops a still-held request being taken twice; gating with rst_n
  // keeps the array untouched while reset is asserted.
  assign accept  = rst_n && bus.ss && bus.bstart && !bdone_q;
  assign shifted = rword_i >> {lane, 3'b000};

  always_comb begin
    misaligned = 1'b0;
    be_sel     = 4'b1111;
    wdata_o    = bus.wdata;
    rfmt       = rword_i;
    case (bus.tsize)
      2'b00: begin
        be_sel  = 4'b0001 << lane;
        wdata_o = {4{bus.wdata[7:0]}};
        rfmt    = {24'b0, shifted[7:0]};
      end
      2'b01: begin
        misaligned = lane[0];
        be_sel     = lane[1] ? 4'b1100 : 4'b0011;
        wdata_o    = {2{bus.wdata[15:0]}};
        rfmt       = {16'b0, shifted[15:0]};
      end
      default: misaligned = |lane;
    endcase
  end

  assign be_o = (accept && bus.ttype && !misaligned) ? be_sel : 4'b0000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bdone_q  <= 1'b0;
      berror_q <= 1'b0;
      rdata_q  <= 32'b0;
    end else begin
      bdone_q  <= accept;
      berror_q <= accept && misaligned;
      // Writes leave rdata alone; a misaligned read returns zero.
      if (accept && !bus.ttype) rdata_q <= misaligned ? 32'b0 : rfmt;
    end
  end

  assign bus.bdone  = bdone_q;
  assign bus.berror = berror_q;
  assign bus.rdata  = rdata_q;
endmodule

module memory_wrapped #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       rst_n,
  slave_bus_if.slave ibus,
  slave_bus_if.slave dbus
);
  logic [AW-1:0] i_idx, d_idx;
  logic [3:0]    i_be, d_be;
  logic [31:0]   i_wdata, d_wdata;
  logic [31:0]   i_rword, d_rword;

  memory_wrapped_port #(.AW(AW)) u_ibus (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (ibus),
    .rword_i (i_rword),
    .idx_o   (i_idx),
    .be_o    (i_be),
    .wdata_o (i_wdata)
  );

  memory_wrapped_port #(.AW(AW)) u_dbus (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (dbus),
    .rword_i (d_rword),
    .idx_o   (d_idx),
    .be_o    (d_be),
    .wdata_o (d_wdata)
  );

  memory_wrapped_mem #(.DEPTH(DEPTH), .AW(AW)) wrapped_mem (
    .clk       (clk),
    .a_idx_i   (i_idx),
    .a_be_i    (i_be),
    .a_wdata_i (i_wdata),
    .b_idx_i   (d_idx),
    .b_be_i    (d_be),
    .b_wdata_i (d_wdata),
    .a_rword_o (i_rword),
    .b_rword_o (d_rword)
  );
endmodule

// File: tb/tb_memory_wrapped.sv
// tb/tb_memory_wrapped.sv - scoreboard testbench for memory_wrapped
module tb_memory_wrapped;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  slave_bus_if ibus_if ();
  slave_bus_if dbus_if ();

  memory_wrapped #(.DEPTH(1024)) mem0 (
    .clk   (clk),
    .rst_n (rst_n),
    .ibus  (ibus_if),
    .dbus  (dbus_if)
  );

  typedef struct {
    bit          en;
    bit          wr;
    logic [31:0] addr;
    logic [1:0]  sz;
    logic [31:0] wd;
  } txn_t;

  typedef struct {
    logic [31:0] rdata;
    bit          berr;
  } exp_t;

  int          n_vec = 0;
  int          n_fail = 0;
  logic [31:0] model [0:1023];
  logic [31:0] last_rd_i = 32'h0;
  logic [31:0] last_rd_d = 32'h0;
  exp_t        q_i [$];
  exp_t        q_d [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit is_mis(input logic [31:0] addr, input logic [1:0] sz);
    return (int'(addr % 4) % nbytes(sz)) != 0;
  endfunction

  function automatic int widx(input logic [31:0] addr);
    return int'((addr >> 2) % 1024);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] addr, input logic [1:0] sz);
    logic [31:0] v;
    logic [31:0] mask;
    int nb;
    nb   = nbytes(sz);
    v    = model[widx(addr)] >> (8 * int'(addr % 4));
    mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'h1);
    return v & mask;
  endfunction

  task automatic model_write(input logic [31:0] addr, input logic [1:0] sz, input logic [31:0] wd);
    int w;
    int ln;
    w = widx(addr);
    for (int i = 0; i < nbytes(sz); i++) begin
      ln = int'(addr % 4) + i;
      model[w][8*ln +: 8] = wd[8*i +: 8];
    end
  endtask

  function automatic txn_t idle();
    txn_t t;
    t.en = 0; t.wr = 0; t.addr = '0; t.sz = '0; t.wd = '0;
    return t;
  endfunction

  function automatic txn_t mk(input bit wr, input logic [31:0] addr, input logic [1:0] sz,
                              input logic [31:0] wd);
    txn_t t;
    t.en = 1; t.wr = wr; t.addr = addr; t.sz = sz; t.wd = wd;
    return t;
  endfunction

  task automatic drive_idle();
    ibus_if.ss = 0; ibus_if.bstart = 0; ibus_if.ttype = 0;
    ibus_if.addr = '0; ibus_if.tsize = '0; ibus_if.wdata = '0;
    dbus_if.ss = 0; dbus_if.bstart = 0; dbus_if.ttype = 0;
    dbus_if.addr = '0; dbus_if.tsize = '0; dbus_if.wdata = '0;
  endtask

  // Issued at a negedge; expectations from the model before any write is applied.
  task automatic issue(input txn_t ti, input txn_t td);
    exp_t ei, ed;
    if (ti.en) begin
      ei.berr  = is_mis(ti.addr, ti.sz);
      ei.rdata = ti.wr ? last_rd_i : (ei.berr ? 32'h0 : model_read(ti.addr, ti.sz));
      last_rd_i = ei.rdata;
      q_i.push_back(ei);
    end
    if (td.en) begin
      ed.berr  = is_mis(td.addr, td.sz);
      ed.rdata = td.wr ? last_rd_d : (ed.berr ? 32'h0 : model_read(td.addr, td.sz));
      last_rd_d = ed.rdata;
      q_d.push_back(ed);
    end
    if (ti.en && ti.wr && !is_mis(ti.addr, ti.sz)) model_write(ti.addr, ti.sz, ti.wd);
    if (td.en && td.wr && !is_mis(td.addr, td.sz)) model_write(td.addr, td.sz, td.wd);
    ibus_if.ss = ti.en; ibus_if.bstart = ti.en; ibus_if.ttype = ti.wr;
    ibus_if.addr = ti.addr; ibus_if.tsize = ti.sz; ibus_if.wdata = ti.wd;
    dbus_if.ss = td.en; dbus_if.bstart = td.en; dbus_if.ttype = td.wr;
    dbus_if.addr = td.addr; dbus_if.tsize = td.sz; dbus_if.wdata = td.wd;
    @(posedge clk);
    @(negedge clk);
    chk("bdone_i_latency", {31'b0, ibus_if.bdone}, {31'b0, ti.en});
    chk("bdone_d_latency", {31'b0, dbus_if.bdone}, {31'b0, td.en});
    drive_idle();
    @(negedge clk);
  endtask

  // Monitor: pops an expectation whenever a port presents bdone.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (ibus_if.bdone === 1'b1) begin
        if (q_i.size() == 0) chk("unexpected_bdone_i", 32'h1, 32'h0);
        else begin
          e = q_i.pop_front();
          chk("rdata_i", ibus_if.rdata, e.rdata);
          chk("berror_i", {31'b0, ibus_if.berror}, {31'b0, e.berr});
        end
      end
      if (dbus_if.bdone === 1'b1) begin
        if (q_d.size() == 0) chk("unexpected_bdone_d", 32'h1, 32'h0);
        else begin
          e = q_d.pop_front();
          chk("rdata_d", dbus_if.rdata, e.rdata);
          chk("berror_d", {31'b0, dbus_if.berror}, {31'b0, e.berr});
        end
      end
    end
  end

  initial begin
    txn_t ti, td;
    int mode;
    for (int i = 0; i < 1024; i++) model[i] = 32'h0;
    drive_idle();

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_bdone_i", {31'b0, ibus_if.bdone}, 32'h0);
    chk("rst_berror_i", {31'b0, ibus_if.berror}, 32'h0);
    chk("rst_rdata_i", ibus_if.rdata, 32'h0);
    chk("rst_bdone_d", {31'b0, dbus_if.bdone}, 32'h0);
    chk("rst_rdata_d", dbus_if.rdata, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Boot image
    issue(idle(), mk(1, 32'hF000_0000, 2'b10, 32'h0000_0013));
    issue(idle(), mk(1, 32'hF000_0004, 2'b10, 32'hDEAD_BEEF));
    issue(mk(0, 32'hF000_0000, 2'b10, 0), idle());
    chk("boot_word0", ibus_if.rdata, 32'h0000_0013);
    issue(mk(0, 32'hF000_0004, 2'b10, 0), idle());
    chk("boot_word1", ibus_if.rdata, 32'hDEAD_BEEF);

    // Sub-word access
    issue(idle(), mk(1, 32'hF000_0100, 2'b10, 32'h0011_2233));
    issue(idle(), mk(1, 32'hF000_0102, 2'b00, 32'h0000_00AB));
    issue(idle(), mk(0, 32'hF000_0100, 2'b10, 0));
    chk("byte_write_lane", dbus_if.rdata, 32'h00AB_2233);
    issue(idle(), mk(0, 32'hF000_0102, 2'b01, 0));
    chk("half_read_upper", dbus_if.rdata, 32'h0000_00AB);

    // Misaligned word write: error strobe, memory untouched
    issue(idle(), mk(1, 32'hF000_0001, 2'b10, 32'hFFFF_FFFF));
    issue(idle(), mk(0, 32'hF000_0000, 2'b10, 0));
    chk("misaligned_nowrite", dbus_if.rdata, 32'h0000_0013);

    // Dual-port collision on word 8
    issue(idle(), mk(1, 32'hF000_0020, 2'b10, 32'hCAFE_F00D));
    issue(mk(0, 32'hF000_0020, 2'b10, 0), mk(1, 32'hF000_0020, 2'b10, 32'h1234_5678));
    chk("collision_old", ibus_if.rdata, 32'hCAFE_F00D);
    issue(mk(0, 32'hF000_0020, 2'b10, 0), idle());
    chk("collision_new", ibus_if.rdata, 32'h1234_5678);

    // Continuous bstart: accepts every other edge
    for (int k = 0; k < 4; k++) begin
      exp_t e;
      e.rdata = 32'h0000_0013; e.berr = 0;
      q_i.push_back(e);
    end
    last_rd_i = 32'h0000_0013;
    ibus_if.ss = 1; ibus_if.bstart = 1; ibus_if.ttype = 0;
    ibus_if.addr = 32'hF000_0000; ibus_if.tsize = 2'b10;
    for (int k = 0; k < 7; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_bdone_pattern", {31'b0, ibus_if.bdone}, (k % 2 == 0) ? 32'h1 : 32'h0);
    end
    drive_idle();
    @(negedge clk);

    // ss low: bstart ignored
    ibus_if.ss = 0; ibus_if.bstart = 1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("ss_low_no_bdone", {31'b0, ibus_if.bdone}, 32'h0);
    end
    drive_idle();
    @(negedge clk);

    // Random traffic over a small window so collisions happen
    for (int w = 1; w < 8; w++) issue(idle(), mk(1, 32'hF000_0100 + 32'(w * 4), 2'b10, $urandom));
    for (int n = 0; n < 300; n++) begin
      ti = mk(1'($urandom_range(0, 1)), 32'hF000_0100 + 32'($urandom_range(0, 31)),
              2'($urandom_range(0, 3)), $urandom);
      td = mk(1'($urandom_range(0, 1)), 32'hF000_0100 + 32'($urandom_range(0, 31)),
              2'($urandom_range(0, 3)), $urandom);
      mode = $urandom_range(0, 2);
      if (mode == 0) td = idle();
      if (mode == 1) ti = idle();
      issue(ti, td);
    end

    // Reset one cycle after an accepted read
    issue(idle(), mk(0, 32'hF000_0004, 2'b10, 0));
    begin
      exp_t e;
      e.rdata = 32'hDEAD_BEEF; e.berr = 0;
      q_i.push_back(e);
    end
    ibus_if.ss = 1; ibus_if.bstart = 1; ibus_if.ttype = 0;
    ibus_if.addr = 32'hF000_0004; ibus_if.tsize = 2'b10;
    @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    drive_idle();
    #1;
    chk("async_rst_bdone_i", {31'b0, ibus_if.bdone}, 32'h0);
    chk("async_rst_berror_i", {31'b0, ibus_if.berror}, 32'h0);
    chk("async_rst_rdata_i", ibus_if.rdata, 32'h0);
    chk("async_rst_rdata_d", dbus_if.rdata, 32'h0);
    last_rd_i = 32'h0;
    last_rd_d = 32'h0;
    // Write attempt during reset must not land
    @(negedge clk);
    dbus_if.ss = 1; dbus_if.bstart = 1; dbus_if.ttype = 1;
    dbus_if.addr = 32'hF000_0104; dbus_if.tsize = 2'b10; dbus_if.wdata = 32'hFFFF_FFFF;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      chk("in_reset_no_bdone", {31'b0, dbus_if.bdone}, 32'h0);
    end
    drive_idle();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(mk(0, 32'hF000_0004, 2'b10, 0), mk(0, 32'hF000_0104, 2'b10, 0));
    chk("persist_after_reset", ibus_if.rdata, 32'hDEAD_BEEF);

    repeat (2) @(negedge clk);
    chk("queue_i_drained", 32'(q_i.size()), 32'h0);
    chk("queue_d_drained", 32'(q_d.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
